// File: rtl/line_window_buffer_if.sv
// line_window_buffer_if: pixel-in / window-out stream bundle for line_window_buffer.
//   s_data/s_valid/s_sof/s_ready : raster pixel stream (s_sof marks pixel (0,0))
//   m_window/m_valid/m_sof/m_eof/m_ready : one KSIZE x KSIZE window per pixel
//   m_row/m_col : centre coordinate, present only with LINE_WINDOW_BUFFER_COORD_EN
// Modports: slave = the buffer itself, master = the producer/consumer side.
interface line_window_buffer_if #(
  parameter int DATA_WIDTH = 12,
  parameter int KSIZE      = 5,
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240
);
  logic signed [DATA_WIDTH-1:0]          s_data;
  logic                                  s_valid;
  logic                                  s_sof;
  logic                                  s_ready;
  logic [KSIZE*KSIZE*DATA_WIDTH-1:0]     m_window;
  logic                                  m_valid;
  logic                                  m_sof;
  logic                                  m_eof;
  logic                                  m_ready;
`ifdef LINE_WINDOW_BUFFER_COORD_EN
  logic [$clog2(HEIGHT)-1:0]             m_row;
  logic [$clog2(WIDTH)-1:0]              m_col;
`endif

  modport slave (
    input  s_data, s_valid, s_sof, m_ready,
    output s_ready, m_window, m_valid, m_sof, m_eof
`ifdef LINE_WINDOW_BUFFER_COORD_EN
    , output m_row, m_col
`endif
  );

  modport master (
    output s_data, s_valid, s_sof, m_ready,
    input  s_ready, m_window, m_valid, m_sof, m_eof
`ifdef LINE_WINDOW_BUFFER_COORD_EN
    , input m_row, m_col
`endif
  );
endinterface

// File: rtl/line_window_buffer.sv
// line_window_buffer: streams raster pixels in and emits one centred KSIZE x KSIZE
// window per image pixel (WIDTH*HEIGHT windows per frame). Out-of-image taps are
// zero (BORDER_MODE=0) or replicate the nearest edge pixel (BORDER_MODE=1).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : line_window_buffer_if.slave (pixel stream in, window stream out)
// Optional: define LINE_WINDOW_BUFFER_COORD_EN to add m_row/m_col (window centre).
//
// Datapath: KSIZE-1 line memories act as W-pixel delay lines; each advance shifts
// a new column {lines..., pixel} into a KSIZE x KSIZE raw window. The raw window is
// always a contiguous raster neighbourhood, so in-range taps are read directly and
// border taps are substituted from the output pixel's (row,col). FLUSH keeps
// advancing with dummy pixels; those only ever land in out-of-range taps.
module line_window_buffer #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int DATA_WIDTH  = 12,
  parameter int KSIZE       = 5,
  parameter int BORDER_MODE = 0
)(
  input logic clk,
  input logic rst_n,
  line_window_buffer_if.slave bus
);
  localparam int R  = (KSIZE-1)/2;
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int IW = $clog2(KSIZE);
  localparam int WW = KSIZE*KSIZE*DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, FLUSH} state_e;

  state_e          state_q;
  logic [RW-1:0]   in_row_q, o_row_q;   // next input pixel / next window centre
  logic [CW-1:0]   in_col_q, o_col_q;
  logic            eof_done_q;          // last window of the frame already loaded
  logic [WW-1:0]   m_window_q;
  logic            m_valid_q, m_sof_q, m_eof_q;
`ifdef LINE_WINDOW_BUFFER_COORD_EN
  logic [RW-1:0]   m_row_q;
  logic [CW-1:0]   m_col_q;
`endif

  logic [DATA_WIDTH-1:0] lmem_q  [KSIZE-1][WIDTH];
  logic [DATA_WIDTH-1:0] raw_q   [KSIZE][KSIZE];
  logic [DATA_WIDTH-1:0] raw_nx  [KSIZE][KSIZE];
  logic [DATA_WIDTH-1:0] col_new [KSIZE];
  logic [WW-1:0]         win_d;

  logic s_ready, slot_free, acc, restart, flush_gen, adv, load;
  logic prime_last, in_last, out_last;
  logic [CW-1:0] wr_col;

  assign slot_free  = !m_valid_q || bus.m_ready;
  assign prime_last = (in_row_q == RW'(R)) && (in_col_q == CW'(R));
  assign in_last    = (in_row_q == RW'(HEIGHT-1)) && (in_col_q == CW'(WIDTH-1));
  assign out_last   = (o_row_q == RW'(HEIGHT-1)) && (o_col_q == CW'(WIDTH-1));

  // The accept that completes priming loads window (0,0), so it must also
  // respect a stalled output register (possible after a mid-frame resync).
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      IDLE:    s_ready = 1'b1;
      PRIME:   s_ready = prime_last ? slot_free : 1'b1;
      STREAM:  s_ready = slot_free;
      default: s_ready = 1'b0;
    endcase
  end
  assign bus.s_ready = s_ready;

  assign acc       = bus.s_valid && s_ready;
  assign restart   = acc && bus.s_sof;
  assign flush_gen = (state_q == FLUSH) && slot_free && !eof_done_q;
  assign adv       = restart || (acc && state_q != IDLE) || flush_gen;
  assign load      = (acc && !bus.s_sof &&
                      (state_q == STREAM || (state_q == PRIME && prime_last))) || flush_gen;
  // A resync pixel is always column 0 regardless of where the old frame stopped.
  assign wr_col    = restart ? '0 : in_col_q;

  always_comb begin
    for (int i = 0; i < KSIZE-1; i++) col_new[i] = lmem_q[KSIZE-2-i][wr_col];
    col_new[KSIZE-1] = bus.s_data;
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE-1; j++) raw_nx[i][j] = raw_q[i][j+1];
      raw_nx[i][KSIZE-1] = col_new[i];
    end
  end

  // Border substitution per tap, relative to the window being loaded.
  for (genvar i = 0; i < KSIZE; i++) begin : g_row
    for (genvar j = 0; j < KSIZE; j++) begin : g_col
      int pr, pc;
      assign pr = int'(o_row_q) + i - R;
      assign pc = int'(o_col_q) + j - R;
      if (BORDER_MODE == 0) begin : g_zero
        logic inr;
        assign inr = (pr >= 0) && (pr < HEIGHT) && (pc >= 0) && (pc < WIDTH);
        assign win_d[(i*KSIZE+j)*DATA_WIDTH +: DATA_WIDTH] = inr ? raw_nx[i][j] : '0;
      end else begin : g_repl
        // Clamping the image coordinate equals clamping the tap index.
        logic [IW-1:0] si, sj;
        assign si = (pr < 0)       ? IW'(R - int'(o_row_q)) :
                    (pr >= HEIGHT) ? IW'(HEIGHT-1 - int'(o_row_q) + R) : IW'(i);
        assign sj = (pc < 0)       ? IW'(R - int'(o_col_q)) :
                    (pc >= WIDTH)  ? IW'(WIDTH-1 - int'(o_col_q) + R) : IW'(j);
        assign win_d[(i*KSIZE+j)*DATA_WIDTH +: DATA_WIDTH] = raw_nx[si][sj];
      end
    end
  end

  // Storage: contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      raw_q <= raw_nx;
      lmem_q[0][wr_col] <= bus.s_data;
      for (int k = 1; k < KSIZE-1; k++) lmem_q[k][wr_col] <= lmem_q[k-1][wr_col];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_row_q   <= '0;
      in_col_q   <= '0;
      o_row_q    <= '0;
      o_col_q    <= '0;
      eof_done_q <= 1'b0;
    end else if (restart) begin
      state_q    <= PRIME;
      in_row_q   <= '0;
      in_col_q   <= CW'(1);
      o_row_q    <= '0;
      o_col_q    <= '0;
      eof_done_q <= 1'b0;
    end else begin
      if (adv) begin
        if (in_col_q == CW'(WIDTH-1)) begin
          in_col_q <= '0;
          in_row_q <= in_row_q + 1'b1;
        end else begin
          in_col_q <= in_col_q + 1'b1;
        end
      end
      if (load) begin
        if (o_col_q == CW'(WIDTH-1)) begin
          o_col_q <= '0;
          o_row_q <= o_row_q + 1'b1;
        end else begin
          o_col_q <= o_col_q + 1'b1;
        end
        if (out_last) eof_done_q <= 1'b1;
      end
      case (state_q)
        PRIME:   if (acc && prime_last) state_q <= STREAM;
        STREAM:  if (acc && in_last)    state_q <= FLUSH;
        FLUSH:   if (m_valid_q && bus.m_ready && m_eof_q) state_q <= IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_window_q <= '0;
      m_valid_q  <= 1'b0;
      m_sof_q    <= 1'b0;
      m_eof_q    <= 1'b0;
`ifdef LINE_WINDOW_BUFFER_COORD_EN
      m_row_q    <= '0;
      m_col_q    <= '0;
`endif
    end else if (load) begin
      m_window_q <= win_d;
      m_valid_q  <= 1'b1;
      m_sof_q    <= (o_row_q == '0) && (o_col_q == '0);
      m_eof_q    <= out_last;
`ifdef LINE_WINDOW_BUFFER_COORD_EN
      m_row_q    <= o_row_q;
      m_col_q    <= o_col_q;
`endif
    end else if (bus.m_ready) begin
      m_valid_q  <= 1'b0;
      m_sof_q    <= 1'b0;
      m_eof_q    <= 1'b0;
    end
  end

  assign bus.m_window = m_window_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_sof    = m_sof_q;
  assign bus.m_eof    = m_eof_q;
`ifdef LINE_WINDOW_BUFFER_COORD_EN
  assign bus.m_row    = m_row_q;
  assign bus.m_col    = m_col_q;
`endif
endmodule

// File: tb/tb_line_window_buffer.sv
module tb_line_window_buffer;
  localparam int W = 8, H = 6, DW = 12, K = 5, R = 2;
  localparam int WW = K*K*DW;
  localparam int NPIX = W*H;
  localparam int PRIME_N = R*W+R+1;   // accepts before the first window
  localparam int TAIL = R*W+R;        // windows produced by the flush

  typedef struct { int r; int c; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] s_data = '0;
  logic s_valid = 1'b0, s_sof = 1'b0, m_ready = 1'b1;
  logic mr_rand = 1'b0;

  line_window_buffer_if #(.DATA_WIDTH(DW), .KSIZE(K), .WIDTH(W), .HEIGHT(H)) b0();
  line_window_buffer_if #(.DATA_WIDTH(DW), .KSIZE(K), .WIDTH(W), .HEIGHT(H)) b1();

  line_window_buffer #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .KSIZE(K), .BORDER_MODE(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  line_window_buffer #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .KSIZE(K), .BORDER_MODE(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  assign b0.s_data = s_data;  assign b1.s_data = s_data;
  assign b0.s_valid = s_valid; assign b1.s_valid = s_valid;
  assign b0.s_sof = s_sof;    assign b1.s_sof = s_sof;
  assign b0.m_ready = m_ready; assign b1.m_ready = m_ready;

  logic mv[2], msof[2], meof[2], srdy[2];
  logic [WW-1:0] mw[2];
  assign mv[0] = b0.m_valid;   assign mv[1] = b1.m_valid;
  assign msof[0] = b0.m_sof;   assign msof[1] = b1.m_sof;
  assign meof[0] = b0.m_eof;   assign meof[1] = b1.m_eof;
  assign srdy[0] = b0.s_ready; assign srdy[1] = b1.s_ready;
  assign mw[0] = b0.m_window;  assign mw[1] = b1.m_window;

  int checks = 0, passes = 0;
  int cyc = 0;
  int acc19 = -1, first_vld = -1;
  int nwin[2] = '{0, 0};
  int expected_total = 0;
  exp_t q0[$], q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] pix(input int r, input int c);
    return DW'(r*16 + c);
  endfunction

  function automatic logic [DW-1:0] tap(input logic [WW-1:0] w, input int i, input int j);
    return w[(i*K+j)*DW +: DW];
  endfunction

  // Reference window from the pixel formula and the border policy.
  function automatic logic [WW-1:0] model(input int r, input int c, input int mode);
    logic [WW-1:0] w;
    int pr, pc;
    w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        pr = r+i-R; pc = c+j-R;
        if (mode == 1) begin
          pr = (pr < 0) ? 0 : (pr > H-1) ? H-1 : pr;
          pc = (pc < 0) ? 0 : (pc > W-1) ? W-1 : pc;
          w[(i*K+j)*DW +: DW] = pix(pr, pc);
        end else if (pr >= 0 && pr < H && pc >= 0 && pc < W) begin
          w[(i*K+j)*DW +: DW] = pix(pr, pc);
        end
      end
    return w;
  endfunction

  task automatic push(input int idx);
    exp_t e;
    e.r = idx / W; e.c = idx % W;
    q0.push_back(e); q1.push_back(e);
    expected_total++;
  endtask

  // m_ready driver
  initial forever begin
    @(posedge clk); #1;
    m_ready = mr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    logic stall[2];
    logic [WW-1:0] held[2];
    exp_t e;
    int qs;
    stall[0] = 1'b0; stall[1] = 1'b0;
    held[0] = '0; held[1] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall[0] = 1'b0; stall[1] = 1'b0;
      end else begin
        for (int id = 0; id < 2; id++) begin
          if (stall[id]) begin
            chk($sformatf("hold_valid%0d", id), WW'(mv[id]), WW'(1));
            chk($sformatf("hold_window%0d", id), mw[id], held[id]);
          end
          if (id == 0 && mv[0] && first_vld < 0) first_vld = cyc;
          if (mv[id] && m_ready) begin
            qs = (id == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
              checks++;
              $display("FAIL unexpected_window%0d: got a window, want none", id);
            end else begin
              e = (id == 0) ? q0.pop_front() : q1.pop_front();
              nwin[id]++;
              chk($sformatf("window%0d(%0d,%0d)", id, e.r, e.c), mw[id], model(e.r, e.c, id));
              chk($sformatf("sof%0d(%0d,%0d)", id, e.r, e.c), WW'(msof[id]), WW'(e.r == 0 && e.c == 0));
              chk($sformatf("eof%0d(%0d,%0d)", id, e.r, e.c), WW'(meof[id]), WW'(e.r == H-1 && e.c == W-1));
`ifdef LINE_WINDOW_BUFFER_COORD_EN
              if (id == 0) begin
                chk("m_row", WW'(b0.m_row), WW'(e.r));
                chk("m_col", WW'(b0.m_col), WW'(e.c));
              end
`endif
              if (id == 0 && e.r == 0 && e.c == 0) begin
                chk("z00_centre", WW'(tap(mw[0], 2, 2)), WW'(12'h000));
                chk("z00_tap23",  WW'(tap(mw[0], 2, 3)), WW'(12'h001));
                chk("z00_tap32",  WW'(tap(mw[0], 3, 2)), WW'(12'h010));
                chk("z00_tap00",  WW'(tap(mw[0], 0, 0)), WW'(12'h000));
              end
              if (id == 1 && e.r == 5 && e.c == 7) begin
                chk("r57_tap44", WW'(tap(mw[1], 4, 4)), WW'(12'h057));
                chk("r57_tap00", WW'(tap(mw[1], 0, 0)), WW'(12'h035));
                chk("r57_tap20", WW'(tap(mw[1], 2, 0)), WW'(12'h055));
              end
            end
          end
          stall[id] = mv[id] && !m_ready;
          held[id] = mw[id];
        end
      end
    end
  end

  // Offer one pixel; returns at posedge+1 after it was accepted.
  task automatic send(input int r, input int c, input logic sof, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin s_valid = 1'b0; @(posedge clk); #1; end
    s_data = pix(r, c); s_sof = sof; s_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!srdy[0] && t < 300) begin t++; @(negedge clk); end
    if (!srdy[0]) begin
      checks++;
      $display("FAIL accept_timeout: got s_ready=0 for %0d cycles, want accept", t);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic frame(input int npix, input int rnd);
    for (int k = 0; k < npix; k++) begin
      send(k / W, k % W, k == 0, rnd ? int'($urandom_range(0, 1)) : 0);
      if (k == PRIME_N-1 && acc19 < 0) acc19 = cyc;
      if (k+1 >= PRIME_N) push(k+1-PRIME_N);
    end
    if (npix == NPIX) for (int x = NPIX-TAIL; x < NPIX; x++) push(x);
  endtask

  // s_ready must stay low until the eof window is handed off, then IDLE.
  task automatic flush_check();
    int t;
    logic bad;
    t = 0; bad = 1'b0;
    @(negedge clk);
    while (!(mv[0] && m_ready && meof[0]) && t < 500) begin
      if (srdy[0] || srdy[1]) bad = 1'b1;
      t++; @(negedge clk);
    end
    if (srdy[0] || srdy[1]) bad = 1'b1;
    chk("flush_s_ready_low", WW'(bad), WW'(0));
    chk("flush_timeout", WW'(t >= 500), WW'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_s_ready", WW'({srdy[1], srdy[0]}), WW'(2'b11));
    @(posedge clk); #1;
  endtask

  initial begin
    int t;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_m_valid",  WW'({mv[1], mv[0]}), WW'(0));
    chk("rst_m_window0", mw[0], '0);
    chk("rst_m_window1", mw[1], '0);
    chk("rst_sof_eof",  WW'({msof[1], msof[0], meof[1], meof[0]}), WW'(0));
    chk("rst_s_ready",  WW'({srdy[1], srdy[0]}), WW'(2'b11));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Continuous frame, then back-to-back frame
    frame(NPIX, 0);
    flush_check();
    chk("first_valid_latency", WW'(first_vld), WW'(acc19));
    chk("frame1_count", WW'(nwin[0]), WW'(NPIX));
    frame(NPIX, 0);
    flush_check();

    // Random s_valid / m_ready
    mr_rand = 1'b1;
    frame(NPIX, 1);
    flush_check();

    // Resync after 30 pixels
    frame(30, 1);
    frame(NPIX, 1);
    flush_check();

    // Reset in the middle of FLUSH
    mr_rand = 1'b0;
    @(posedge clk); #1;
    frame(NPIX, 0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", WW'({mv[1], mv[0]}), WW'(0));
    chk("midrst_window0", mw[0], '0);
    chk("midrst_window1", mw[1], '0);
    expected_total -= q0.size();
    q0.delete(); q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrst_s_ready", WW'({srdy[1], srdy[0]}), WW'(2'b11));
    @(posedge clk); #1;
    for (int k = 0; k < 25; k++) send(k / W, k % W, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("nosof_ignored", WW'({mv[1], mv[0]}), WW'(0));
    @(posedge clk); #1;
    frame(NPIX, 0);
    flush_check();

    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 1000) begin @(negedge clk); t++; end
    chk("drain", WW'(q0.size() + q1.size()), WW'(0));
    chk("total_windows0", WW'(nwin[0]), WW'(expected_total));
    chk("total_windows1", WW'(nwin[1]), WW'(expected_total));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
